// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_e;

    localparam int unsigned NUM_REQ_DEF      = 4;
    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned BUSY_TIMEOUT_DEF = 16;

    function automatic int unsigned grant_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first eligible requester scanning upward from i_ptr,
// restricted to i_owner while a message lock is held.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [GRANT_W-1:0] i_ptr,
    input  logic               i_lock,
    input  logic [GRANT_W-1:0] i_owner,
    output logic [NUM_REQ-1:0] o_onehot_c,
    output logic [GRANT_W-1:0] o_index_c,
    output logic               o_any_c
);

    logic [GRANT_W-1:0] w_scan;

    always_comb begin
        o_onehot_c = '0;
        o_index_c  = '0;
        o_any_c    = 1'b0;
        w_scan     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan = GRANT_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_any_c && i_valid[w_scan] && (!i_lock || (w_scan == i_owner))) begin
                o_any_c            = 1'b1;
                o_index_c          = w_scan;
                o_onehot_c[w_scan] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grant with a
// message lock, one-cycle tx_valid pulses, and a watchdog on the tx_busy rise.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = NUM_REQ_DEF,
    parameter  int unsigned DATA_W       = DATA_W_DEF,
    parameter  int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    localparam int unsigned GRANT_W      = grant_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      locked,
    output logic                      timeout_err
);

    localparam int unsigned WDOG_W = $clog2(BUSY_TIMEOUT + 1);

    state_e              r_state, w_state_nxt;
    logic                r_tx_valid, w_tx_valid_nxt;
    logic [DATA_W-1:0]   r_tx_data, w_tx_data_nxt;
    logic [GRANT_W-1:0]  r_grant_id, w_grant_id_nxt;
    logic [GRANT_W-1:0]  r_ptr, w_ptr_nxt;
    logic                r_locked, w_locked_nxt;
    logic                r_timeout_err, w_timeout_err_nxt;
    logic [WDOG_W-1:0]   r_wdog, w_wdog_nxt;

    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [GRANT_W-1:0]  w_win_index;
    logic                w_win_any;
    logic                w_offer;
    logic                w_accept;

    function automatic logic [GRANT_W-1:0] ptr_after(input logic [GRANT_W-1:0] id);
        return (32'(id) == NUM_REQ - 1) ? '0 : id + GRANT_W'(1);
    endfunction

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .i_valid    (req_valid),
        .i_ptr      (r_ptr),
        .i_lock     (r_locked),
        .i_owner    (r_grant_id),
        .o_onehot_c (w_win_onehot),
        .o_index_c  (w_win_index),
        .o_any_c    (w_win_any)
    );

    // Ready is offered only in IDLE with the serializer free and reset released.
    assign w_offer   = rst_n && (r_state == IDLE) && !tx_busy;
    assign req_ready = w_offer ? w_win_onehot : '0;
    assign w_accept  = w_offer && w_win_any;

    always_comb begin
        w_state_nxt       = r_state;
        w_tx_valid_nxt    = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_grant_id_nxt    = r_grant_id;
        w_ptr_nxt         = r_ptr;
        w_locked_nxt      = r_locked;
        w_timeout_err_nxt = 1'b0;
        w_wdog_nxt        = r_wdog;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tx_data_nxt  = req_data[32'(w_win_index) * DATA_W +: DATA_W];
                    w_grant_id_nxt = w_win_index;
                    w_tx_valid_nxt = 1'b1;
                    w_locked_nxt   = !req_last[w_win_index];
                    if (req_last[w_win_index]) begin
                        w_ptr_nxt = ptr_after(w_win_index);
                    end
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_wdog_nxt  = '0;
                w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_wdog == WDOG_W'(BUSY_TIMEOUT - 1)) begin
                    // Serializer never started: drop the lock and move on.
                    w_timeout_err_nxt = 1'b1;
                    w_locked_nxt      = 1'b0;
                    w_ptr_nxt         = ptr_after(r_grant_id);
                    w_state_nxt       = IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + WDOG_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_ptr         <= '0;
            r_locked      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_ptr         <= w_ptr_nxt;
            r_locked      <= w_locked_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_wdog        <= w_wdog_nxt;
        end
    end

    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign locked      = r_locked;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a reactive uart_tx busy model,
// and a transaction-level arbitration model checked every cycle.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_last  = '0;
    logic [NR-1:0]    req_ready;
    logic             tx_valid;
    logic [DW-1:0]    tx_data;
    logic             tx_busy   = 1'b0;
    logic [1:0]       grant_id;
    logic             locked;
    logic             timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s0       = 0;

    beat_t q [NR][$];

    // reference model: arbitration bookkeeping in transaction terms
    int         m_ptr, m_grant, m_age, m_win;
    bit         m_free, m_locked, m_seen, m_txv, m_to;
    logic [7:0] m_txdata;

    // knobs, uart busy schedule, observation logs
    bit k_glitch, k_withdraw, k_refill, k_rdrop, k_rrst, k_rst_wait;
    int k_drop, k_dmax, k_lmin, k_lmax, rst_hold;
    int u_start, u_end;
    int ev_grant[$];
    int ev_data[$];
    int ev_to, first_txv, to_cyc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int j = 0; j < exp.size(); j++) begin
            chk(tag, (j < got.size()) ? 32'(got[j]) : 32'hFFFF_FFFF, 32'(exp[j]));
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_grant = 0; m_age = 0; m_win = -1;
        m_free = 1'b1; m_locked = 1'b0; m_seen = 1'b0; m_txv = 1'b0; m_to = 1'b0;
        m_txdata = 8'h00;
    endtask

    task automatic knobs_directed();
        k_glitch = 0; k_withdraw = 0; k_refill = 0; k_rdrop = 0; k_rrst = 0; k_rst_wait = 0;
        k_drop = 0; k_dmax = 1; k_lmin = 3; k_lmax = 3; rst_hold = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        q[r].push_back(beat_t'{data: d, last: l});
    endtask

    task automatic drive();
        int len;
        for (int i = 0; i < NR; i++) begin
            if (k_refill && q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(1, 3));
                for (int j = 0; j < len; j++) push(i, 8'($urandom), (j == len - 1));
            end
        end
        if (k_glitch && cyc >= u_end && $urandom_range(0, 29) == 0) begin
            u_start = cyc;
            u_end   = cyc + int'($urandom_range(1, 4));
        end
        tx_busy = (cyc >= u_start) && (cyc < u_end);
        rst_n = 1'b1;
        if (rst_hold > 0) begin
            rst_n = 1'b0;
            rst_hold--;
        end else if (k_rst_wait && !m_free && m_seen && tx_busy) begin
            rst_n = 1'b0;
            k_rst_wait = 0;
        end else if (k_rrst && $urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0 && (!k_withdraw || $urandom_range(0, 7) != 0)) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = q[i][0].data;
                req_last[i]           = q[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = 8'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
    endtask

    task automatic check_outputs();
        logic [NR-1:0] e_rdy;
        int idx;
        m_win = -1;
        if (rst_n && m_free && !tx_busy) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (m_win < 0 && req_valid[idx] && (!m_locked || idx == m_grant)) m_win = idx;
            end
        end
        e_rdy = '0;
        if (m_win >= 0) e_rdy[m_win] = 1'b1;
        chk("req_ready",   32'(req_ready),   32'(e_rdy));
        chk("tx_valid",    32'(tx_valid),    32'(m_txv));
        chk("tx_data",     32'(tx_data),     32'(m_txdata));
        chk("grant_id",    32'(grant_id),    32'(m_grant));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        // uart_tx stand-in reacts to the start pulse it actually sees
        if (tx_valid === 1'b1) begin
            ev_grant.push_back(int'(grant_id));
            ev_data.push_back(int'(tx_data));
            if (first_txv < 0) first_txv = cyc;
            if (k_drop > 0) begin
                k_drop--;
            end else if (!(k_rdrop && $urandom_range(0, 7) == 0)) begin
                u_start = cyc + int'($urandom_range(1, k_dmax));
                u_end   = u_start + int'($urandom_range(k_lmin, k_lmax));
            end
        end
        if (timeout_err === 1'b1) begin
            ev_to++;
            to_cyc = cyc;
        end
    endtask

    task automatic model_step();
        beat_t b;
        bit    txv_n, to_n;
        txv_n = 1'b0;
        to_n  = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_free) begin
            if (m_win >= 0) begin
                b = q[m_win].pop_front();
                m_grant  = m_win;
                m_txdata = b.data;
                m_locked = !b.last;
                if (b.last) m_ptr = (m_win + 1) % NR;
                m_free = 1'b0;
                m_seen = 1'b0;
                m_age  = 1;
                txv_n  = 1'b1;
            end
        end else begin
            // age counts cycles since the accept; busy must rise within TO cycles after the pulse
            if (m_seen) begin
                if (!tx_busy) m_free = 1'b1;
            end else if (m_age >= 2) begin
                if (tx_busy) begin
                    m_seen = 1'b1;
                end else if (m_age == 1 + TO) begin
                    to_n     = 1'b1;
                    m_locked = 1'b0;
                    m_ptr    = (m_grant + 1) % NR;
                    m_free   = 1'b1;
                end
            end
            m_age++;
        end
        if (rst_n) begin
            m_txv = txv_n;
            m_to  = to_n;
        end
    endtask

    task automatic run(input int n);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            drive();
            #1;
            check_outputs();
            model_step();
            cyc++;
        end
    endtask

    task automatic start_scn();
        for (int i = 0; i < NR; i++) q[i].delete();
        knobs_directed();
        u_start = 0;
        u_end   = 0;
        rst_hold = 2;
        run(2);
        ev_grant.delete();
        ev_data.delete();
        ev_to = 0;
        first_txv = -1;
        to_cyc = -1;
        s0 = cyc;
    endtask

    initial begin
        int exp_q[$];
        model_reset();
        knobs_directed();
        u_start = 0; u_end = 0;
        ev_to = 0; first_txv = -1; to_cyc = -1;

        // reset with every requester asserting: ready must stay low, outputs at reset values
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < 2; j++) push(i, 8'((i << 4) | j), 1'b1);
        end
        rst_hold = 3;
        run(3);
        @(posedge clk);
        #1;
        chk("rst_req_ready",   32'(req_ready),   32'd0);
        chk("rst_tx_valid",    32'(tx_valid),    32'd0);
        chk("rst_tx_data",     32'(tx_data),     32'd0);
        chk("rst_grant_id",    32'(grant_id),    32'd0);
        chk("rst_locked",      32'(locked),      32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);

        // contention: all four single-byte requesters
        ev_grant.delete(); ev_data.delete();
        run(120);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_seq("contend_grant", ev_grant, exp_q);

        // single requester, busy rises two cycles after accept
        start_scn();
        push(0, 8'h41, 1'b1);
        run(30);
        chk("single_txv_lat", 32'(first_txv - s0), 32'd1);
        exp_q = '{8'h41};
        chk_seq("single_data", ev_data, exp_q);

        // locked three-byte message from req1 holds off req2
        start_scn();
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h20, 1'b1);
        run(60);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h20};
        chk_seq("lock_data", ev_data, exp_q);
        exp_q = '{1, 1, 1, 2};
        chk_seq("lock_grant", ev_grant, exp_q);

        // watchdog: busy never rises for the first byte of a locked message
        start_scn();
        k_drop = 1;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1);
        run(80);
        chk("wdog_pulses", 32'(ev_to), 32'd1);
        chk("wdog_delay", 32'(to_cyc - first_txv), 32'(1 + TO));
        exp_q = '{0, 1, 0};
        chk_seq("wdog_grant", ev_grant, exp_q);

        // reset while the serializer is busy: pointer restarts at req0
        start_scn();
        k_lmin = 4; k_lmax = 4; k_rst_wait = 1;
        push(0, 8'h50, 1'b1); push(0, 8'h51, 1'b1);
        push(1, 8'h60, 1'b1);
        run(60);
        exp_q = '{0, 0, 1};
        chk_seq("rstmid_grant", ev_grant, exp_q);
        exp_q = '{8'h50, 8'h51, 8'h60};
        chk_seq("rstmid_data", ev_data, exp_q);

        // externally busy serializer in IDLE blocks req3
        start_scn();
        u_start = cyc; u_end = cyc + 6;
        push(3, 8'h33, 1'b1);
        run(30);
        chk("extbusy_txv_lat", 32'(first_txv - s0), 32'd7);
        exp_q = '{3};
        chk_seq("extbusy_grant", ev_grant, exp_q);

        // randomized traffic: withdrawals, busy glitches, dropped starts, stray resets
        start_scn();
        k_glitch = 1; k_withdraw = 1; k_refill = 1; k_rdrop = 1; k_rrst = 1;
        k_dmax = 4; k_lmin = 1; k_lmax = 6;
        run(4000);
        chk("random_traffic_seen", 32'(ev_grant.size() > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
